// File: rtl/register_file.sv
// Eight-entry register file: three combinational read ports, one synchronous write port.
// Optional build macro REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module register_file #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Reg_Write,
    input  logic [ADDR_WIDTH-1:0] Reg_input_address,
    input  logic [DATA_WIDTH-1:0] Reg_input_data,
    input  logic [ADDR_WIDTH-1:0] Reg_address1,
    input  logic [ADDR_WIDTH-1:0] Reg_address2,
    input  logic [ADDR_WIDTH-1:0] Reg_address3,
    output logic [DATA_WIDTH-1:0] Reg_output1,
    output logic [DATA_WIDTH-1:0] Reg_output2,
    output logic [DATA_WIDTH-1:0] Reg_output3
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en;

`ifdef REGFILE_R0_ZERO_EN
    assign wr_en = Reg_Write && (Reg_input_address != '0);
`else
    assign wr_en = Reg_Write;
`endif

    // Reset wins over a coincident write.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[Reg_input_address] <= Reg_input_data;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] addr);
`ifdef REGFILE_R0_ZERO_EN
        return (addr == '0) ? '0 : regs[addr];
`else
        return regs[addr];
`endif
    endfunction

    // No write-through: reads see the stored value until the write edge.
    assign Reg_output1 = read_reg(Reg_address1);
    assign Reg_output2 = read_reg(Reg_address2);
    assign Reg_output3 = read_reg(Reg_address3);

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: driver pushes expected reads from an array model,
// a negedge monitor pops and compares them against the three read ports.
`timescale 1ns/1ps
module tb_register_file;

    typedef struct {
        logic [2:0]  a1, a2, a3;
        logic [15:0] e1, e2, e3;
    } exp_t;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  wa = '0;
    logic [15:0] wd = '0;
    logic [2:0]  ra1 = '0, ra2 = '0, ra3 = '0;
    logic [15:0] rd1, rd2, rd3;

    int unsigned model [8];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;

    register_file dut (
        .CLK               (clk),
        .Reset             (reset),
        .Reg_Write         (we),
        .Reg_input_address (wa),
        .Reg_input_data    (wd),
        .Reg_address1      (ra1),
        .Reg_address2      (ra2),
        .Reg_address3      (ra3),
        .Reg_output1       (rd1),
        .Reg_output2       (rd2),
        .Reg_output3       (rd3)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_read(input logic [2:0] a);
        if (R0_ZERO && a == 3'd0) return 16'h0000;
        return 16'(model[a]);
    endfunction

    task automatic compare(input string name, input logic [2:0] a,
                           input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s addr=%0d got=%h expected=%h at %0t", name, a, got, exp, $time);
        end
    endtask

    // Monitor: reads are combinational, so each queued expectation is due at the next negedge.
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            compare("port1", mon_e.a1, rd1, mon_e.e1);
            compare("port2", mon_e.a2, rd2, mon_e.e2);
            compare("port3", mon_e.a3, rd3, mon_e.e3);
        end
    end

    // One clock: drive, queue expected pre-edge reads, then apply the edge to the model.
    task automatic cycle(input logic r, input logic w, input logic [2:0] a_w,
                         input logic [15:0] d, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [2:0] a3, input bit chk);
        exp_t e;
        reset = r; we = w; wa = a_w; wd = d;
        ra1 = a1; ra2 = a2; ra3 = a3;
        if (chk) begin
            e.a1 = a1; e.a2 = a2; e.a3 = a3;
            e.e1 = model_read(a1);
            e.e2 = model_read(a2);
            e.e3 = model_read(a3);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) model[i] = 0;
        end else if (w && !(R0_ZERO && a_w == 3'd0)) begin
            model[a_w] = int'(d);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        // Reset coverage with read sweep
        cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 3'd0, 1'b0);
        for (int a = 0; a < 8; a++)
            cycle(1'b1, 1'b0, 3'd0, 16'h0000, 3'(a), 3'(a + 1), 3'(a + 2), 1'b1);
        // Write then read; first check also shows no bypass
        cycle(1'b0, 1'b1, 3'd1, 16'h1234, 3'd1, 3'd2, 3'd3, 1'b1);
        cycle(1'b0, 1'b0, 3'd1, 16'h0000, 3'd1, 3'd2, 3'd3, 1'b1);
        // Write disabled
        cycle(1'b0, 1'b0, 3'd1, 16'hFFFF, 3'd1, 3'd1, 3'd1, 1'b1);
        cycle(1'b0, 1'b0, 3'd1, 16'hFFFF, 3'd1, 3'd1, 3'd1, 1'b1);
        // Multi-port read
        cycle(1'b0, 1'b1, 3'd7, 16'hA5A5, 3'd7, 3'd7, 3'd7, 1'b1);
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd7, 3'd7, 1'b1);
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 3'd6, 1'b1);
        // Reset beats write
        cycle(1'b1, 1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd1, 3'd7, 1'b1);
        for (int a = 0; a < 8; a++)
            cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'(a), 3'(7 - a), 3'd2, 1'b1);
        // Register 0
        cycle(1'b0, 1'b1, 3'd0, 16'h5555, 3'd0, 3'd1, 3'd2, 1'b1);
        cycle(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 3'd0, 1'b1);
        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0), 1'($urandom),
                  3'($urandom), 16'($urandom),
                  3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
        end
        @(negedge clk); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Eight-entry, 16-bit general-purpose register file for the processor datapath, with three asynchronous read ports and one synchronous write port. Operand fetch reads up to three registers per cycle; writeback commits one result per clock edge when `Reg_Write` is high. A synchronous reset clears every register to zero.

## Interface

Parameters:
- `DATA_WIDTH`, default 16: register width in bits.
- `ADDR_WIDTH`, default 3: address width; depth is 2^ADDR_WIDTH = 8 entries.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: synchronous, active-high; clears all registers on the rising edge of `CLK`.
- `Reg_Write`  in  1: write enable; high commits `Reg_input_data` to `Reg_input_address`.
- `Reg_input_address`  in  3: write address.
- `Reg_input_data`  in  16: write data.
- `Reg_address1`  in  3: read address, port 1.
- `Reg_address2`  in  3: read address, port 2.
- `Reg_address3`  in  3: read address, port 3.
- `Reg_output1`  out  16: contents of register `Reg_address1`.
- `Reg_output2`  out  16: contents of register `Reg_address2`.
- `Reg_output3`  out  16: contents of register `Reg_address3`.

## Operation

- Storage: 8 registers × 16 bits, indexed 0–7.
- Reads: purely combinational.
  - `Reg_outputN = reg[Reg_addressN]`, independently for N = 1, 2, 3.
  - Any number of ports may address the same register.
- Write: on a rising `CLK` edge with `Reset` = 0 and `Reg_Write` = 1, `reg[Reg_input_address] <= Reg_input_data`.
  - Only the addressed entry changes.
- Hold: with `Reg_Write` = 0, no register changes, whatever the value of the data or address inputs.
- Reset:
  - On a rising edge with `Reset` = 1, all 8 registers become 0x0000.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Reset asserted in the middle of a write sequence clears everything, including values written in earlier cycles.
- Outputs after reset: all three outputs read 0x0000 for every address.
- No write-through bypass. A read of the register being written returns the old value until the edge, and the new value immediately after it.
- Unknown (X) addresses are not sanitised; the bench must drive defined addresses.

## Timing

- Read latency: 0 cycles (combinational from address and register state).
- Write latency: 1 edge. Data is visible on any read port addressing that register from the rising edge at which it is written.
- Reset latency: 1 edge. Outputs are 0x0000 after the first rising edge with `Reset` high.
- Before the first reset edge, register contents are undefined.
- Inputs must be stable around the rising `CLK` edge (setup/hold); there is no handshake.

## Configuration

- Macro `REGFILE_R0_ZERO_EN`.
  - Defined:
    - Register 0 is hardwired to zero.
    - Writes to address 0 are ignored.
    - Reads of address 0 on any port always return 0x0000.
  - Undefined (default):
    - Register 0 is an ordinary storage register, written and read like registers 1–7.

## Test plan

1. Reset coverage: hold `Reset`=1 for at least 1 edge with `Reg_Write`=0, and sweep the read addresses over 0–7. Required: all outputs read 0x0000.
2. Write then read:
   - Drive `Reset`=0, `Reg_Write`=1, write address 1, data 0x1234, read addresses 1/2/3, then apply 1 edge.
   - Required: `Reg_output1`=0x1234, `Reg_output2`=0x0000, `Reg_output3`=0x0000.
3. Write disabled: `Reg_Write`=0, `Reg_input_data`=0xFFFF, write address 1, 1 edge. Required: `Reg_output1` still reads 0x1234.
4. Multi-port read: write 0xA5A5 to register 7, then point all three read addresses at 7. Required: all three outputs read 0xA5A5; other registers are unchanged.
5. Reset beats write: `Reset`=1 and `Reg_Write`=1, write address 2, data 0xBEEF, 1 edge. Required: register 2 reads 0x0000, and so do all other registers.
6. Register 0:
   - Write 0x5555 to address 0, then read it on port 1.
   - Required: 0x0000 with `REGFILE_R0_ZERO_EN` defined; 0x5555 without it.
